// File: rtl/slc3_pkg.sv
// slc3_pkg: shared types and encodings for the SLC-3 control unit.
//   state_e  - control FSM states
//   alu_op_e - ALU operation select driven on aluop
//   op_e     - IR[15:12] opcode values the controller acts on
//   ctrl_t   - bundle of every control output, decoded per state
//   mux-select localparams for PCMUX, DRMUX, ALUMUX, ADDR1MUX, ADDR2MUX, MARMUX
package slc3_pkg;

    typedef enum logic [4:0] {
        S_HALTED,
        S_FETCH1,
        S_FETCH2,
        S_FETCH3,
        S_DECODE,
        S_ADD,
        S_AND,
        S_NOT,
        S_BR1,
        S_BR2,
        S_JMP,
        S_JSR1,
        S_JSR2,     // JSR: PC <- PC + off11
        S_JSRR2,    // JSRR: PC <- BaseR through the ALU
        S_LDR1,
        S_LDR2,
        S_LDR3,
        S_STR1,
        S_STR2,
        S_STR3,
        S_PAUSE1,
        S_PAUSE2,
        S_MEM_ERR   // one-cycle timeout indication, then refetch
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_AND    = 4'd1,
        ALU_NOT    = 4'd2,
        ALU_PASS_A = 4'd3,
        ALU_PASS_B = 4'd4
    } alu_op_e;

    typedef enum logic [3:0] {
        OP_BR    = 4'b0000,
        OP_ADD   = 4'b0001,
        OP_JSR   = 4'b0100,
        OP_AND   = 4'b0101,
        OP_LDR   = 4'b0110,
        OP_STR   = 4'b0111,
        OP_NOT   = 4'b1001,
        OP_JMP   = 4'b1100,
        OP_PAUSE = 4'b1101
    } op_e;

    // PCMUX: 00 pc+1, 01 cpu_bus, 10 br_adder
    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;
    // DRMUX: only MDR_In is ever selected
    localparam logic [1:0] DRMUX_MDR   = 2'b00;
    // ALUMUX: 00 sr2mux (01 would select offset6, unused by this controller)
    localparam logic [1:0] ALUMUX_SR2  = 2'b00;
    // ADDR1MUX / ADDR2MUX / MARMUX
    localparam logic       ADDR1_PC    = 1'b0;
    localparam logic       ADDR1_SR1   = 1'b1;
    localparam logic [1:0] ADDR2_OFF11 = 2'b00;
    localparam logic [1:0] ADDR2_OFF9  = 2'b01;
    localparam logic [1:0] ADDR2_OFF6  = 2'b10;
    localparam logic       MARMUX_ADDER = 1'b0;

    typedef struct packed {
        logic       ld_pc;
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       load_regfile;
        logic       load_cc;
        logic       ld_led;
        logic [1:0] pcmux;
        logic [1:0] drmux;
        logic [1:0] alumux_sel;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic       marmux;
        alu_op_e    aluop;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_err;
    } ctrl_t;

    // States that hold a memory strobe and wait for mem_resp.
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
    endfunction

endpackage

// File: rtl/slc3_mem_wait.sv
// slc3_mem_wait: memory wait-cycle counter with timeout compare, plus the
// rising-edge detector for the front-panel cont input.
//   clk, reset  - clock, synchronous active-high reset
//   in_wait     - controller is in a memory wait state this cycle
//   mem_resp    - memory done
//   cont        - front-panel continue level
//   timeout     - in_wait, no response, and this is the last allowed cycle
//   cont_rise   - cont is 1 now and was 0 in the previous cycle
module slc3_mem_wait #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic in_wait,
    input  logic mem_resp,
    input  logic cont,
    output logic timeout,
    output logic cont_rise
);

    // The wait state lasts MEM_TIMEOUT cycles: count runs 0..MEM_TIMEOUT-1.
    localparam logic [7:0] LAST_COUNT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] wait_count_reg;
    logic       cont_prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_count_reg <= 8'd0;
            // Start as "high" so a cont already held at reset release is
            // never taken as a fresh press.
            cont_prev_reg  <= 1'b1;
        end else begin
            // Wait states are never entered from another wait state, so
            // clearing whenever we are outside one gives a zero count on entry.
            if (in_wait && !mem_resp) begin
                wait_count_reg <= wait_count_reg + 8'd1;
            end else begin
                wait_count_reg <= 8'd0;
            end
            cont_prev_reg <= cont;
        end
    end

    assign timeout   = in_wait && !mem_resp && (wait_count_reg == LAST_COUNT);
    assign cont_rise = cont && !cont_prev_reg;

endmodule

// File: rtl/slc3_control.sv
// slc3_control: Moore control FSM sequencing the SLC-3 datapath through
// fetch / decode / execute, the memory read/write handshake and the
// run / pause / continue front-panel protocol.
//   Inputs : clk, reset (sync, active-high), run, cont, opcode (IR[15:12]),
//            branch_enable, jsr_sel (IR[11]), mem_resp
//   Outputs: datapath loads (LD_PC, LD_MAR, LD_MDR, LD_IR, load_regfile,
//            load_cc, ld_led), mux selects (PCMUX, DRMUX, alumux_sel,
//            ADDR1MUX, ADDR2MUX, MARMUX), aluop, bus gates (gate_pc,
//            gate_mdr, gate_alu, gate_marmux), mem_rd, mem_wr, mem_err
// Every output is a function of the current state only.
module slc3_control
    import slc3_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       cont,
    input  logic [3:0] opcode,
    input  logic       branch_enable,
    input  logic       jsr_sel,
    input  logic       mem_resp,
    output logic       LD_PC,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       load_regfile,
    output logic       load_cc,
    output logic       ld_led,
    output logic [1:0] PCMUX,
    output logic [1:0] DRMUX,
    output logic [1:0] alumux_sel,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic       MARMUX,
    output logic [3:0] aluop,
    output logic       gate_pc,
    output logic       gate_mdr,
    output logic       gate_alu,
    output logic       gate_marmux,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       mem_err
);

    state_e state_reg;
    state_e state_next;
    ctrl_t  ctrl;
    logic   in_wait;
    logic   timeout;
    logic   cont_rise;

    assign in_wait = is_wait_state(state_reg);

    slc3_mem_wait #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait (
        .clk       (clk),
        .reset     (reset),
        .in_wait   (in_wait),
        .mem_resp  (mem_resp),
        .cont      (cont),
        .timeout   (timeout),
        .cont_rise (cont_rise)
    );

    // State register. Reset from any state (including a memory wait) lands
    // in HALTED on the next edge; strobes drop with it because outputs are
    // decoded from state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_HALTED;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_HALTED:  if (run) state_next = S_FETCH1;
            S_FETCH1:  state_next = S_FETCH2;
            S_FETCH2: begin
                if (mem_resp)     state_next = S_FETCH3;
                else if (timeout) state_next = S_MEM_ERR;
            end
            S_FETCH3:  state_next = S_DECODE;
            S_DECODE: begin
                case (op_e'(opcode))
                    OP_ADD:   state_next = S_ADD;
                    OP_AND:   state_next = S_AND;
                    OP_NOT:   state_next = S_NOT;
                    OP_BR:    state_next = S_BR1;
                    OP_JMP:   state_next = S_JMP;
                    OP_JSR:   state_next = S_JSR1;
                    OP_LDR:   state_next = S_LDR1;
                    OP_STR:   state_next = S_STR1;
                    OP_PAUSE: state_next = S_PAUSE1;
                    // Unimplemented opcodes act as NOPs; PC already advanced.
                    default:  state_next = S_FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT, S_JMP, S_BR2, S_JSR2, S_JSRR2, S_LDR3,
            S_MEM_ERR:
                state_next = S_FETCH1;
            S_BR1:     state_next = branch_enable ? S_BR2 : S_FETCH1;
            // jsr_sel is resolved here so that JSR2/JSRR2 stay pure Moore states.
            S_JSR1:    state_next = jsr_sel ? S_JSR2 : S_JSRR2;
            S_LDR1:    state_next = S_LDR2;
            S_LDR2: begin
                if (mem_resp)     state_next = S_LDR3;
                else if (timeout) state_next = S_MEM_ERR;
            end
            S_STR1:    state_next = S_STR2;
            S_STR2:    state_next = S_STR3;
            S_STR3: begin
                if (mem_resp)     state_next = S_FETCH1;
                else if (timeout) state_next = S_MEM_ERR;
            end
            // A press already under way during PAUSE1 is honoured too.
            S_PAUSE1:  state_next = cont_rise ? S_FETCH1 : S_PAUSE2;
            S_PAUSE2:  if (cont_rise) state_next = S_FETCH1;
            default:   state_next = S_HALTED;
        endcase
    end

    // Output decode: everything defaults to zero (ALU_ADD is the zero code).
    always_comb begin
        ctrl = '0;
        ctrl.drmux      = DRMUX_MDR;
        ctrl.marmux     = MARMUX_ADDER;
        ctrl.alumux_sel = ALUMUX_SR2;
        case (state_reg)
            S_FETCH1: begin
                ctrl.gate_pc = 1'b1;
                ctrl.ld_mar  = 1'b1;
                ctrl.ld_pc   = 1'b1;
                ctrl.pcmux   = PCMUX_INC;
            end
            S_FETCH2, S_LDR2: begin
                ctrl.mem_rd = 1'b1;
                ctrl.ld_mdr = 1'b1;
            end
            S_FETCH3: begin
                ctrl.gate_mdr = 1'b1;
                ctrl.ld_ir    = 1'b1;
            end
            S_ADD, S_AND, S_NOT: begin
                ctrl.gate_alu     = 1'b1;
                ctrl.load_regfile = 1'b1;
                ctrl.load_cc      = 1'b1;
                ctrl.aluop        = (state_reg == S_ADD) ? ALU_ADD :
                                    (state_reg == S_AND) ? ALU_AND : ALU_NOT;
            end
            S_BR2: begin
                ctrl.pcmux    = PCMUX_ADDER;
                ctrl.addr1mux = ADDR1_PC;
                ctrl.addr2mux = ADDR2_OFF9;
                ctrl.ld_pc    = 1'b1;
            end
            S_JMP, S_JSRR2: begin
                ctrl.aluop    = ALU_PASS_A;
                ctrl.gate_alu = 1'b1;
                ctrl.pcmux    = PCMUX_BUS;
                ctrl.ld_pc    = 1'b1;
            end
            S_JSR1: begin
                // Return address into R7; datapath storemux picks R7 from jsr_sel.
                ctrl.gate_pc      = 1'b1;
                ctrl.load_regfile = 1'b1;
            end
            S_JSR2: begin
                ctrl.pcmux    = PCMUX_ADDER;
                ctrl.addr1mux = ADDR1_PC;
                ctrl.addr2mux = ADDR2_OFF11;
                ctrl.ld_pc    = 1'b1;
            end
            S_LDR1, S_STR1: begin
                ctrl.addr1mux    = ADDR1_SR1;
                ctrl.addr2mux    = ADDR2_OFF6;
                ctrl.gate_marmux = 1'b1;
                ctrl.ld_mar      = 1'b1;
            end
            S_LDR3: begin
                ctrl.gate_mdr     = 1'b1;
                ctrl.load_regfile = 1'b1;
                ctrl.load_cc      = 1'b1;
            end
            S_STR2: begin
                // Source register is addressed through the dest field and
                // passed straight through on the B side.
                ctrl.aluop    = ALU_PASS_B;
                ctrl.gate_alu = 1'b1;
                ctrl.ld_mdr   = 1'b1;
            end
            S_STR3:    ctrl.mem_wr  = 1'b1;
            S_PAUSE1:  ctrl.ld_led  = 1'b1;
            S_MEM_ERR: ctrl.mem_err = 1'b1;
            default: begin
            end
        endcase
    end

    assign LD_PC        = ctrl.ld_pc;
    assign LD_MAR       = ctrl.ld_mar;
    assign LD_MDR       = ctrl.ld_mdr;
    assign LD_IR        = ctrl.ld_ir;
    assign load_regfile = ctrl.load_regfile;
    assign load_cc      = ctrl.load_cc;
    assign ld_led       = ctrl.ld_led;
    assign PCMUX        = ctrl.pcmux;
    assign DRMUX        = ctrl.drmux;
    assign alumux_sel   = ctrl.alumux_sel;
    assign ADDR1MUX     = ctrl.addr1mux;
    assign ADDR2MUX     = ctrl.addr2mux;
    assign MARMUX       = ctrl.marmux;
    assign aluop        = ctrl.aluop;
    assign gate_pc      = ctrl.gate_pc;
    assign gate_mdr     = ctrl.gate_mdr;
    assign gate_alu     = ctrl.gate_alu;
    assign gate_marmux  = ctrl.gate_marmux;
    assign mem_rd       = ctrl.mem_rd;
    assign mem_wr       = ctrl.mem_wr;
    assign mem_err      = ctrl.mem_err;

endmodule
